timeout_scheduler: RTL and testbench
====================================

Name: timeout_scheduler

Overview:
- Shares a single prescaled timebase between N_CH independent countdown timers, e.g. session inactivity, PIN entry and card-eject timeouts.
- Replaces per-timer divided clocks with one free-running prescaler that produces a one-cycle tick enable.
- All logic runs on the system clock.
- Requesters start, retrigger or cancel their channel and receive a one-cycle expiry pulse.

Parameters:
- CLK_DIV, 5_000_000: system clocks per tick. Legal range is 2 or greater.
- N_CH, 4: number of timer channels. Legal range is 1 to 8.
- CNT_W, 8: width of each channel's tick count.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- pause  in  1  level; freezes the prescaler while high, so no ticks are issued.
- start  in  N_CH  per-channel start/retrigger strobe, one cycle each.
- cancel  in  N_CH  per-channel cancel strobe, one cycle each.
- load_val  in  N_CH*CNT_W  per-channel timeout in ticks. Channel i uses bits [i*CNT_W +: CNT_W].
- tick  out  1  one-cycle timebase pulse.
- busy  out  N_CH  channel i is in RUN.
- expired  out  N_CH  one-cycle pulse when channel i times out.

Behaviour:
- Reset (asynchronous, active-high):
  - prescaler count = 0, tick = 0.
  - All channels go to IDLE with remaining = 0.
  - busy = 0, expired = 0.
  - Reset asserted mid-count aborts every channel silently; no expired pulse is produced.
- Prescaler:
  - The counter has width clog2(CLK_DIV).
  - It counts 0..CLK_DIV-1 when pause = 0 and holds its value when pause = 1.
  - tick is registered. It is 1 for exactly one cycle following the cycle in which count == CLK_DIV-1 and pause = 0; count wraps to 0 on that same edge.
  - The prescaler is free-running. start does not resynchronise it, so the first tick after a start arrives 1..CLK_DIV cycles later. Timeout accuracy is load_val ticks, minus up to 1 tick.
- Channel FSM (per channel) has states IDLE, RUN and FIRE.
  - Priority within a channel, highest first: cancel, then start, then tick.
  - cancel (any state): go to IDLE next cycle, remaining = 0, no expired pulse.
  - start with load_val = 0 (any state): go to FIRE next cycle.
  - start with load_val > 0 (any state): go to RUN, remaining = load_val. In RUN this is a retrigger that reloads the count. A tick in the same cycle is ignored for this channel.
  - In RUN, when tick = 1:
    - remaining > 1: remaining decrements by 1.
    - remaining == 1: remaining becomes 0 and the channel goes to FIRE.
  - FIRE lasts one cycle, then the channel goes to IDLE.
    - A start during FIRE is honoured; the channel goes to RUN, or to FIRE again if load_val = 0.
    - A cancel during FIRE does not suppress the expired pulse already being driven.
- Outputs:
  - expired[i] = 1 exactly when channel i is in FIRE. It is registered, one cycle wide, and appears the cycle after the terminal tick.
  - busy[i] = 1 exactly when channel i is in RUN.
- Channels are fully independent and may expire in the same cycle. There is no arbitration loss.
- remaining never underflows. A tick in IDLE or FIRE has no effect on that channel.
- start and cancel on channels that are not driven are tied to 0 by the integrator. Held-high strobes retrigger every cycle, which is legal.

Test Plan (CLK_DIV=4, N_CH=4, CNT_W=8):
- Reset, then idle for 20 cycles -> tick pulses every 4th cycle. busy = 0 and expired = 0 throughout.
- Start ch0 with load_val = 3 right after a tick -> busy[0] is high for the 3 following ticks. expired[0] pulses one cycle after the 3rd tick, then busy[0] = 0.
- Start ch1 with load_val = 5; retrigger with 5 after 2 ticks -> expired[1] fires 5 ticks after the retrigger, not after the original start.
- Start ch2 with load_val = 4; assert cancel[2] and start[2] together after 1 tick -> cancel wins, busy[2] = 0 and expired[2] never pulses.
- Start ch3 with load_val = 0 -> expired[3] pulses on the next cycle, busy[3] stays 0. Separately, start ch0 = 2 and ch1 = 2 together -> both expired bits pulse in the same cycle.
- Start ch0 with load_val = 2, hold pause = 1 for 10 cycles -> no ticks occur and remaining holds. After release, expiry is delayed by exactly 10 cycles.
- Start ch0 with load_val = 2, assert reset mid-run -> all outputs are 0 immediately and no expired pulse follows.

Source files
------------

// File: rtl/timeout_scheduler.sv
// N_CH countdown timers sharing one free-running prescaled tick.
// Each channel counts ticks down from load_val and emits a one-cycle expired pulse.

module timeout_channel #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic             cancel,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy,
    output logic             expired
);
    typedef enum logic [1:0] {IDLE, RUN, FIRE} state_t;

    state_t           state;
    logic [CNT_W-1:0] remaining;

    // busy/expired are registered alongside the state so they mirror RUN/FIRE exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            busy      <= 1'b0;
            expired   <= 1'b0;
        end else begin
            busy    <= 1'b0;
            expired <= 1'b0;
            if (cancel) begin
                state     <= IDLE;
                remaining <= '0;
            end else if (start) begin
                if (load_val == '0) begin
                    state     <= FIRE;
                    remaining <= '0;
                    expired   <= 1'b1;
                end else begin
                    state     <= RUN;
                    remaining <= load_val;
                    busy      <= 1'b1;
                end
            end else begin
                case (state)
                    RUN: begin
                        if (tick && remaining <= CNT_W'(1)) begin
                            state     <= FIRE;
                            remaining <= '0;
                            expired   <= 1'b1;
                        end else begin
                            busy <= 1'b1;
                            if (tick) remaining <= remaining - CNT_W'(1);
                        end
                    end
                    FIRE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

module timeout_scheduler #(
    parameter int CLK_DIV = 5_000_000,
    parameter int N_CH    = 4,
    parameter int CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pause,
    input  logic [N_CH-1:0]       start,
    input  logic [N_CH-1:0]       cancel,
    input  logic [N_CH*CNT_W-1:0] load_val,
    output logic                  tick,
    output logic [N_CH-1:0]       busy,
    output logic [N_CH-1:0]       expired
);
    localparam int            PW   = $clog2(CLK_DIV);
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] count;

    // Free-running: start never resynchronises the prescaler.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (!pause) begin
                if (count == LAST) begin
                    count <= '0;
                    tick  <= 1'b1;
                end else begin
                    count <= count + PW'(1);
                end
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        timeout_channel #(.CNT_W(CNT_W)) u_ch (
            .clk      (clk),
            .reset    (reset),
            .tick     (tick),
            .start    (start[i]),
            .cancel   (cancel[i]),
            .load_val (load_val[i*CNT_W +: CNT_W]),
            .busy     (busy[i]),
            .expired  (expired[i])
        );
    end
endmodule

// File: tb/tb_timeout_scheduler.sv
// Directed bench for timeout_scheduler at CLK_DIV=4, N_CH=4, CNT_W=8.
// cyc counts clock edges since reset release; ticks are visible when cyc%4==0 until the pause test.

module tb_timeout_scheduler;
    localparam int CLK_DIV = 4;
    localparam int N_CH    = 4;
    localparam int CNT_W   = 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  pause;
    logic [N_CH-1:0]       start;
    logic [N_CH-1:0]       cancel;
    logic [N_CH*CNT_W-1:0] load_val;
    logic                  tick;
    logic [N_CH-1:0]       busy;
    logic [N_CH-1:0]       expired;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    timeout_scheduler #(.CLK_DIV(CLK_DIV), .N_CH(N_CH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .pause    (pause),
        .start    (start),
        .cancel   (cancel),
        .load_val (load_val),
        .tick     (tick),
        .busy     (busy),
        .expired  (expired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s @cyc %0d: got %0h exp %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        pause    = 1'b0;
        start    = '0;
        cancel   = '0;
        load_val = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tick", 32'(tick), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_exp",  32'(expired), 0);
        reset = 1'b0;

        // idle: tick every 4th cycle, nothing else moves
        for (int k = 1; k <= 20; k++) begin
            step();
            chk("idle_tick", 32'(tick), (k % 4 == 0) ? 1 : 0);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_exp",  32'(expired), 0);
        end

        // ch0 = 3 started while tick visible: that tick is ignored, fires at 33
        load_val[0*CNT_W +: CNT_W] = 8'd3;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        chk("c0_busy", 32'(busy[0]), 1);
        while (cyc < 34) begin
            step();
            chk("c0_busy", 32'(busy[0]), (cyc <= 32) ? 1 : 0);
            chk("c0_exp",  32'(expired[0]), (cyc == 33) ? 1 : 0);
        end

        // ch1 = 5, retriggered at cyc 45; would fire at 57, must fire at 65
        wait_to(36);
        load_val[1*CNT_W +: CNT_W] = 8'd5;
        start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        chk("c1_busy", 32'(busy[1]), 1);
        while (cyc < 66) begin
            if (cyc == 45) start[1] = 1'b1;
            step();
            start[1] = 1'b0;
            chk("c1_busy", 32'(busy[1]), (cyc <= 64) ? 1 : 0);
            chk("c1_exp",  32'(expired[1]), (cyc == 65) ? 1 : 0);
        end

        // ch2 = 4, cancel+start together at cyc 73: cancel wins
        wait_to(68);
        load_val[2*CNT_W +: CNT_W] = 8'd4;
        start[2] = 1'b1;
        step();
        start[2] = 1'b0;
        while (cyc < 100) begin
            if (cyc == 73) begin
                start[2]  = 1'b1;
                cancel[2] = 1'b1;
            end
            step();
            start[2]  = 1'b0;
            cancel[2] = 1'b0;
            chk("c2_busy", 32'(busy[2]), (cyc <= 73) ? 1 : 0);
            chk("c2_exp",  32'(expired[2]), 0);
        end

        // ch3 = 0 fires next cycle without ever being busy
        load_val[3*CNT_W +: CNT_W] = 8'd0;
        start[3] = 1'b1;
        step();
        start[3] = 1'b0;
        chk("c3_exp",  32'(expired[3]), 1);
        chk("c3_busy", 32'(busy[3]), 0);
        step();
        chk("c3_exp_end", 32'(expired[3]), 0);

        // ch0 = 2 and ch1 = 2 together at cyc 104: both fire at 113
        wait_to(104);
        load_val[0*CNT_W +: CNT_W] = 8'd2;
        load_val[1*CNT_W +: CNT_W] = 8'd2;
        start = 4'b0011;
        step();
        start = '0;
        wait_to(112);
        chk("dual_busy", 32'(busy), 32'h3);
        chk("dual_exp0", 32'(expired), 0);
        step();
        chk("dual_exp",  32'(expired), 32'h3);
        chk("dual_busy_end", 32'(busy), 0);

        // ch0 = 2 at cyc 116, pause over edges 118..127: expiry moves from 125 to 135
        wait_to(116);
        load_val[0*CNT_W +: CNT_W] = 8'd2;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        pause = 1'b1;
        while (cyc < 136) begin
            if (cyc == 127) pause = 1'b0;
            step();
            chk("pz_tick", 32'(tick), (cyc == 130 || cyc == 134) ? 1 : 0);
            chk("pz_busy", 32'(busy[0]), (cyc <= 134) ? 1 : 0);
            chk("pz_exp",  32'(expired[0]), (cyc == 135) ? 1 : 0);
        end

        // ch0 = 2 at cyc 138 (tick), reset mid-run at 141: silent abort
        wait_to(138);
        chk("rr_tick", 32'(tick), 1);
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        wait_to(141);
        chk("rr_busy_pre", 32'(busy[0]), 1);
        reset = 1'b1;
        #1;
        chk("rr_busy", 32'(busy), 0);
        chk("rr_exp",  32'(expired), 0);
        chk("rr_tick0", 32'(tick), 0);
        step();
        step();
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("rr_post_exp",  32'(expired), 0);
            chk("rr_post_busy", 32'(busy), 0);
            chk("rr_post_tick", 32'(tick), (k % 4 == 0) ? 1 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
